spi_slave: RTL and testbench

SPI peripheral-side (responder) endpoint for mode 0 (CPOL=0, CPHA=0), the counterpart of the system's SPI master. It lets the SoC be driven by an external SPI master, for example a host MCU or a second board. Byte frames are MSbit first. With word mode compiled in, 32-bit frames are LSByte first with MSbit first within each byte, matching the master's fast mode. SCLK, MOSI and SS are asynchronous pins, oversampled in the `clk` domain.

---
 rtl/spi_slave.sv | 123 ++++++++++++
 tb/tb_spi_slave.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder with oversampled pins and a one-deep transmit holding register.
// Define SPI_SLAVE_WORD_EN to add the fast input selecting 32-bit LSByte-first frames.
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic [31:0] dataTx,
    input  logic        load,
    output logic        txEmpty,
    output logic [31:0] dataRx,
    output logic        rxValid,
    input  logic        rxAck,
`ifdef SPI_SLAVE_WORD_EN
    input  logic        fast,
`endif
    output logic        overrun
);
`ifdef SPI_SLAVE_WORD_EN
    localparam int CW = 5;
`else
    localparam int CW = 3;
`endif

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
    logic                   sclk_dly_q, ss_dly_q;
    logic                   sel_q, sel_d;
    logic [CW-1:0]          bitcnt_q, bitcnt_d;
    logic [31:0]            tx_q, tx_d, hold_q, hold_d, data_rx_q, data_rx_d;
    logic [30:0]            rx_q, rx_d;
    logic                   tx_full_q, tx_full_d, rx_valid_q, rx_valid_d, overrun_q, overrun_d;
    logic                   sclk_s, mosi_s, ss_s, rise, fall, ss_start, active;
    logic                   last, reload, done, wd;
    logic [31:0]            rx_new, tx_fmt;

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s     = ss_sync_q[SYNC_STAGES-1];
    assign rise     = sclk_s & ~sclk_dly_q;
    assign fall     = ~sclk_s & sclk_dly_q;
    assign ss_start = ~ss_s & ss_dly_q;
    assign active   = sel_q & ~ss_s;

`ifdef SPI_SLAVE_WORD_EN
    logic fast_q;
    assign wd   = ss_start ? fast : fast_q;
    assign last = bitcnt_q == (wd ? 5'd31 : 5'd7);
    always_ff @(posedge clk or posedge rst)
        if (rst) fast_q <= 1'b0;
        else if (ss_start) fast_q <= fast;
`else
    assign wd   = 1'b0;
    assign last = bitcnt_q == 3'd7;
`endif

    // Word frames are byte-swapped so both directions can shift MSbit first from bit 31.
    assign reload = ss_start | (active & fall & (bitcnt_q == '0));
    assign done   = active & rise & last;
    assign rx_new = {rx_q, mosi_s};
    assign tx_fmt = wd ? bswap(hold_q) : {hold_q[7:0], 24'hFF_FFFF};

    always_comb begin
        sel_d      = ss_start | active;
        bitcnt_d   = !active ? '0 : rise ? (last ? '0 : bitcnt_q + CW'(1)) : bitcnt_q;
        tx_d       = reload ? (tx_full_q ? tx_fmt : '1) : (active & fall) ? {tx_q[30:0], 1'b1} : tx_q;
        rx_d       = (active & rise) ? rx_new[30:0] : rx_q;
        data_rx_d  = done ? (wd ? bswap(rx_new) : {24'b0, rx_new[7:0]}) : data_rx_q;
        rx_valid_d = done | (rx_valid_q & ~rxAck);
        overrun_d  = done ? (overrun_q | rx_valid_q) : (overrun_q & ~rxAck);
        tx_full_d  = reload ? load : (tx_full_q | load);
        hold_d     = (load & (reload | ~tx_full_q)) ? dataTx : hold_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '0;
            sclk_dly_q  <= 1'b0;
            ss_dly_q    <= 1'b0;
            sel_q       <= 1'b0;
            bitcnt_q    <= '0;
            tx_q        <= '1;
            rx_q        <= '0;
            hold_q      <= '0;
            data_rx_q   <= '0;
            tx_full_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
            sclk_dly_q  <= sclk_s;
            ss_dly_q    <= ss_s;
            sel_q       <= sel_d;
            bitcnt_q    <= bitcnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            hold_q      <= hold_d;
            data_rx_q   <= data_rx_d;
            tx_full_q   <= tx_full_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign MISO    = sel_q ? tx_q[31] : 1'b1;
    assign MISO_oe = sel_q;
    assign txEmpty = ~tx_full_q;
    assign dataRx  = data_rx_q;
    assign rxValid = rx_valid_q;
    assign overrun = overrun_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized SPI master driving spi_slave, checked against a frame-level model.
// Build with SPI_SLAVE_WORD_EN defined to also exercise 32-bit frames.
module tb_spi_slave;
    localparam int S = 2;
    localparam int H = 8;

    logic        clk = 0, rst = 1, SS = 1, SCLK = 0, MOSI = 0, load = 0, rxAck = 0;
    logic [31:0] dataTx = '0;
    logic        MISO, MISO_oe, txEmpty, rxValid, overrun;
    logic [31:0] dataRx;
`ifdef SPI_SLAVE_WORD_EN
    logic        fast = 0;
`endif
    int          checks = 0, errors = 0;
    logic        m_full = 0, m_valid = 0, m_ovr = 0;
    logic [31:0] m_hold = '0, m_rx = '0, exp_tx = '1;
    int          low_n = 0, high_n = 0;
    bit          armed = 0;

    always #5 clk = ~clk;

    spi_slave #(.SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .SS(SS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe),
        .dataTx(dataTx), .load(load), .txEmpty(txEmpty), .dataRx(dataRx), .rxValid(rxValid),
        .rxAck(rxAck),
`ifdef SPI_SLAVE_WORD_EN
        .fast(fast),
`endif
        .overrun(overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    // MISO_oe must follow the SS pin once it has been stable longer than the synchronizer delay.
    always @(posedge clk) begin
        if (rst) begin
            armed <= 0; low_n <= 0; high_n <= 0;
        end else if (SS) begin
            armed <= 1; high_n <= high_n + 1; low_n <= 0;
        end else begin
            low_n <= low_n + 1; high_n <= 0;
        end
    end

    always @(negedge clk) begin
        if (rst || !armed || high_n >= S + 1) begin
            checks++;
            if (MISO_oe !== 1'b0 || MISO !== 1'b1) begin
                errors++;
                $display("FAIL idle_pins: MISO_oe=%b MISO=%b, expected 0 and 1", MISO_oe, MISO);
            end
        end else if (low_n >= S + 1) begin
            checks++;
            if (MISO_oe !== 1'b1) begin
                errors++;
                $display("FAIL sel_oe: MISO_oe=%b, expected 1", MISO_oe);
            end
        end
    end

    task automatic reload();
        exp_tx = m_full ? m_hold : '1;
        m_full = 0;
    endtask

    task automatic do_load(input logic [31:0] d);
        @(negedge clk);
        dataTx = d;
        load   = 1;
        @(negedge clk);
        load   = 0;
        if (!m_full) begin
            m_full = 1;
            m_hold = d;
        end
        chk1("txEmpty_load", txEmpty, !m_full);
    endtask

    task automatic do_ack();
        @(negedge clk);
        rxAck = 1;
        @(negedge clk);
        rxAck = 0;
        m_valid = 0;
        m_ovr   = 0;
        chk1("rxValid_ack", rxValid, 1'b0);
    endtask

    // Wire order: byte 0 first, MSbit first within each byte.
    task automatic send_bits(input int nbits, input logic [31:0] w, output logic [31:0] cap);
        cap = '1;
        for (int k = 0; k < nbits; k++) begin
            int idx;
            idx = 8 * (k / 8) + 7 - (k % 8);
            @(negedge clk);
            MOSI = w[idx];
            repeat (H - 1) @(negedge clk);
            SCLK = 1;
            cap[idx] = MISO;
            repeat (H) @(negedge clk);
            SCLK = 0;
        end
    endtask

    task automatic begin_sel(input bit f);
        @(negedge clk);
`ifdef SPI_SLAVE_WORD_EN
        fast = f;
`else
        if (f) $display("word frame requested in byte-only build");
`endif
        SS = 0;
        reload();
    endtask

    task automatic end_sel();
        repeat (S) @(negedge clk);
        SS = 1;
        repeat (2 * S + 4) @(negedge clk);
    endtask

    task automatic do_frame(input int n, input logic [31:0] w, input bit mid_load,
                            input logic [31:0] ld, output logic [31:0] cap);
        logic [31:0] e;
        e = exp_tx;
        fork
            send_bits(8 * n, w, cap);
            if (mid_load) begin
                repeat ($urandom_range(H, 16 * H * n - 2 * H)) @(negedge clk);
                do_load(ld);
            end
        join
        if (n == 1) chk("miso_byte", {24'b0, cap[7:0]}, {24'b0, e[7:0]});
        else chk("miso_word", cap, e);
        if (m_valid) m_ovr = 1;
        m_valid = 1;
        m_rx    = (n == 1) ? {24'b0, w[7:0]} : w;
        reload();
        repeat (S + 3) @(negedge clk);
        chk("dataRx", dataRx, m_rx);
        chk1("rxValid", rxValid, m_valid);
        chk1("overrun", overrun, m_ovr);
        chk1("txEmpty_frame", txEmpty, !m_full);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cap;
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (S + 4) @(negedge clk);
        chk1("rst_oe", MISO_oe, 1'b0);
        chk1("rst_miso", MISO, 1'b1);
        chk1("rst_txEmpty", txEmpty, 1'b1);
        chk1("rst_rxValid", rxValid, 1'b0);
        chk1("rst_overrun", overrun, 1'b0);
        chk("rst_dataRx", dataRx, 32'h0);

        do_load(32'h0000_00A5);
        begin_sel(0);
        do_frame(1, 32'h0000_003C, 0, 0, cap);
        chk("t1_miso", {24'b0, cap[7:0]}, 32'hA5);
        chk("t1_dataRx", dataRx, 32'h3C);
        chk1("t1_txEmpty", txEmpty, 1'b1);
        end_sel();

        do_ack();
        do_load(32'h0000_00A5);
        begin_sel(0);
        do_frame(1, 32'h0000_0001, 1, 32'h0000_005A, cap);
        chk("t2_miso0", {24'b0, cap[7:0]}, 32'hA5);
        do_frame(1, 32'h0000_0002, 0, 0, cap);
        chk("t2_miso1", {24'b0, cap[7:0]}, 32'h5A);
        chk1("t2_overrun", overrun, 1'b1);
        chk("t2_dataRx", dataRx, 32'h02);
        end_sel();

        do_ack();
        begin_sel(0);
        send_bits(4, 32'h0000_000A, cap);
        chk("t3_partial_miso", {28'b0, cap[7:4]}, 32'hF);
        end_sel();
        chk1("t3_no_valid", rxValid, 1'b0);
        begin_sel(0);
        do_frame(1, 32'h0000_00C3, 0, 0, cap);
        chk("t3_miso", {24'b0, cap[7:0]}, 32'hFF);
        chk("t3_dataRx", dataRx, 32'hC3);
        end_sel();

`ifdef SPI_SLAVE_WORD_EN
        do_ack();
        do_load(32'h1122_3344);
        begin_sel(1);
        do_frame(4, 32'hDEAD_BEEF, 0, 0, cap);
        chk("w_first_byte", {24'b0, cap[7:0]}, 32'h44);
        chk("w_second_byte", {24'b0, cap[15:8]}, 32'h33);
        chk("w_miso", cap, 32'h1122_3344);
        chk("w_dataRx", dataRx, 32'hDEAD_BEEF);
        end_sel();
`endif

        do_load(32'h0000_0077);
        begin_sel(0);
        send_bits(3, 32'h0000_00F0, cap);
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk1("arst_oe", MISO_oe, 1'b0);
        chk1("arst_miso", MISO, 1'b1);
        chk1("arst_txEmpty", txEmpty, 1'b1);
        chk1("arst_rxValid", rxValid, 1'b0);
        chk1("arst_overrun", overrun, 1'b0);
        chk("arst_dataRx", dataRx, 32'h0);
        m_full = 0; m_valid = 0; m_ovr = 0; m_rx = '0;
        @(negedge clk);
        rst = 0;
        SS  = 1;
        repeat (2 * S + 4) @(negedge clk);
        do_load(32'h0000_0081);
        begin_sel(0);
        do_frame(1, 32'h0000_0066, 0, 0, cap);
        chk("arst_next_miso", {24'b0, cap[7:0]}, 32'h81);
        chk("arst_next_dataRx", dataRx, 32'h66);
        end_sel();

        for (int it = 0; it < 30; it++) begin
            bit f;
            int nfr;
`ifdef SPI_SLAVE_WORD_EN
            f = 1'($urandom_range(0, 1));
`else
            f = 0;
`endif
            if ($urandom_range(0, 1) == 1) do_load($urandom);
            if ($urandom_range(0, 3) == 0) begin
                begin_sel(f);
                send_bits($urandom_range(1, 7), $urandom, cap);
                end_sel();
                chk1("rnd_partial_valid", rxValid, m_valid);
                chk("rnd_partial_data", dataRx, m_rx);
            end
            begin_sel(f);
            nfr = $urandom_range(1, 2);
            for (int j = 0; j < nfr; j++)
                do_frame(f ? 4 : 1, $urandom, 1'($urandom_range(0, 1)), $urandom, cap);
            end_sel();
            if ($urandom_range(0, 1) == 1) do_ack();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
